imem_boot_loader: RTL and testbench

//   Upstream stage of the single-cycle core. Receives a program image as a byte stream
//   and writes it, one 32-bit word at a time, into the instruction memory's write port.

---
 rtl/imem_boot_loader_if.sv | 20 ++
 rtl/imem_boot_loader.sv | 148 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive channel plus instruction-memory write port used by the boot loader.
// The master side is the loader; the slave side is the byte source and the memory.
interface imem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory and
// keeps the core in reset until a complete image has been verified.
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int LEN_W = 16
) (
  input  logic               globalclock,
  input  logic               globalreset,
  input  logic               start,
  imem_boot_loader_if.master bus,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [7:0]       len_hi;
  logic [7:0]       chk;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift;
  logic             xfer;
  logic             last_word;
  logic             can_start;
  logic             rx_ready_q;
  logic             imem_we_q;
  logic [31:0]      imem_addr_q;
  logic [31:0]      imem_wdata_q;

  assign xfer      = bus.rx_valid & rx_ready_q;
  assign len_full  = LEN_W'({len_hi, bus.rx_data});
  assign last_word = (word_idx == len - LEN_W'(1));
  assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;

  always_ff @(posedge globalclock or posedge globalreset) begin
    if (globalreset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame parser: the length is checked as soon as its low byte arrives so an
  // oversize image is rejected before any memory write happens.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == '0)                   next_state = S_CHECK;
          else if (len_full > LEN_W'(DEPTH))    next_state = S_ERR;
          else                                  next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3 && last_word) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (xfer) next_state = (bus.rx_data == chk) ? S_DONE : S_ERR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the
  // state register; the write strobe fires the cycle after a word's fourth byte.
  always_ff @(posedge globalclock or posedge globalreset) begin
    if (globalreset) begin
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      len_hi       <= '0;
      len          <= '0;
      chk          <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      shift        <= '0;
    end else begin
      rx_ready_q <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                    (next_state == S_DATA)   || (next_state == S_CHECK);
      busy       <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                    (next_state == S_DATA)   || (next_state == S_CHECK);
      done       <= (next_state == S_DONE);
      error      <= (next_state == S_ERR);
      cpu_reset  <= (next_state != S_DONE);
      imem_we_q  <= 1'b0;

      if (can_start) begin
        len_hi   <= '0;
        len      <= '0;
        chk      <= '0;
        byte_cnt <= '0;
        word_idx <= '0;
        shift    <= '0;
      end

      case (state)
        S_LEN_HI: if (xfer) len_hi <= bus.rx_data;
        S_LEN_LO: if (xfer) len <= len_full;
        S_DATA: begin
          if (xfer) begin
            chk      <= chk ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], bus.rx_data};
            if (byte_cnt == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_wdata_q <= {shift, bus.rx_data};
              imem_addr_q  <= 32'({word_idx, 2'b00});
              if (!last_word) word_idx <= word_idx + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed test of the boot loader: framing, write strobes, checksum, length limits
// and mid-frame reset recovery.
module tb_imem_boot_loader;
  logic globalclock;
  logic globalreset;
  logic start;
  logic cpu_reset;
  logic busy;
  logic done;
  logic error;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_boot_loader_if bus();

  imem_boot_loader #(.DEPTH(256), .LEN_W(16)) dut (
    .globalclock(globalclock),
    .globalreset(globalreset),
    .start(start),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial globalclock = 1'b0;
  always #5 globalclock = ~globalclock;

  // Every write strobe seen on the memory port is logged mid-cycle.
  always @(negedge globalclock) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered and left just after a rising edge; one byte is offered until taken.
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.rx_valid = 1'b0;
      @(posedge globalclock); #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    @(negedge globalclock);
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge globalclock);
    end
    if (bus.rx_ready !== 1'b1) checkOutput("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge globalclock); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) applyStimulus(w[8*i +: 8], gap && (i % 2 == 0));
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge globalclock); #1;
    start = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_ready"},   32'(bus.rx_ready), 32'd0);
    checkOutput({tag, "_imem_we"},    32'(bus.imem_we),  32'd0);
    checkOutput({tag, "_imem_addr"},  bus.imem_addr,     32'd0);
    checkOutput({tag, "_imem_wdata"}, bus.imem_wdata,    32'd0);
    checkOutput({tag, "_cpu_reset"},  32'(cpu_reset),    32'd1);
    checkOutput({tag, "_busy"},       32'(busy),         32'd0);
    checkOutput({tag, "_done"},       32'(done),         32'd0);
    checkOutput({tag, "_error"},      32'(error),        32'd0);
  endtask

  initial begin
    globalreset  = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge globalclock);
    checkResetState("reset");
    @(posedge globalclock); #1;
    globalreset = 1'b0;

    // Test 1: single word; a byte offered during the start cycle must not be taken.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    startPulse();
    bus.rx_valid = 1'b0;
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_rx_ready", 32'(bus.rx_ready), 32'd1);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    sendWord(32'h8C010004, 1'b0);
    checkOutput("t1_cpu_reset_pre", 32'(cpu_reset), 32'd1);
    applyStimulus(8'h89, 1'b0);
    checkOutput("t1_cpu_reset_post", 32'(cpu_reset), 32'd0);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      checkOutput("t1_addr0", wr_addr[0], 32'h0);
      checkOutput("t1_data0", wr_data[0], 32'h8C010004);
    end

    // Test 2: three words with rx_valid dropping before every other byte.
    wr_addr.delete(); wr_data.delete();
    startPulse();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h03, 1'b0);
    sendWord(32'h12345678, 1'b1);
    sendWord(32'hDEADBEEF, 1'b1);
    sendWord(32'h0F1E2D3C, 1'b1);
    applyStimulus(8'h2A, 1'b1);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_error", 32'(error), 32'd0);
    checkOutput("t2_nwr", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() >= 3) begin
      checkOutput("t2_addr0", wr_addr[0], 32'h0);
      checkOutput("t2_addr1", wr_addr[1], 32'h4);
      checkOutput("t2_addr2", wr_addr[2], 32'h8);
      checkOutput("t2_data0", wr_data[0], 32'h12345678);
      checkOutput("t2_data1", wr_data[1], 32'hDEADBEEF);
      checkOutput("t2_data2", wr_data[2], 32'h0F1E2D3C);
    end

    // Test 3: two words followed by a wrong checksum (correct one is 00).
    wr_addr.delete(); wr_data.delete();
    startPulse();
    checkOutput("t3_done_cleared", 32'(done), 32'd0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h02, 1'b0);
    sendWord(32'h11111111, 1'b0);
    sendWord(32'h22222222, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("t3_error", 32'(error), 32'd1);
    checkOutput("t3_done", 32'(done), 32'd0);
    checkOutput("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("t3_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      checkOutput("t3_data0", wr_data[0], 32'h11111111);
      checkOutput("t3_data1", wr_data[1], 32'h22222222);
      checkOutput("t3_addr1", wr_addr[1], 32'h4);
    end

    // Test 4: length one beyond the memory size is rejected immediately.
    wr_addr.delete(); wr_data.delete();
    startPulse();
    checkOutput("t4_error_cleared", 32'(error), 32'd0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("t4_error", 32'(error), 32'd1);
    checkOutput("t4_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge globalclock);
    #1;
    checkOutput("t4_nwr", 32'(wr_addr.size()), 32'd0);

    // Test 5: empty images with good and bad checksums.
    startPulse();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("t5a_done", 32'(done), 32'd1);
    checkOutput("t5a_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("t5a_nwr", 32'(wr_addr.size()), 32'd0);
    startPulse();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    checkOutput("t5b_error", 32'(error), 32'd1);
    checkOutput("t5b_done", 32'(done), 32'd0);

    // Test 6: reset after six data bytes, then a clean reload with a stray start.
    startPulse();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h02, 1'b0);
    sendWord(32'hAABBCCDD, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    globalreset = 1'b1;
    #1;
    checkResetState("t6_reset");
    @(posedge globalclock); #1;
    globalreset = 1'b0;
    wr_addr.delete(); wr_data.delete();
    startPulse();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'hCA, 1'b0);
    applyStimulus(8'hFE, 1'b0);
    startPulse();
    checkOutput("t6_busy_after_start", 32'(busy), 32'd1);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h0D, 1'b0);
    sendWord(32'h89ABCDEF, 1'b0);
    applyStimulus(8'hC9, 1'b0);
    checkOutput("t6_done", 32'(done), 32'd1);
    checkOutput("t6_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      checkOutput("t6_addr0", wr_addr[0], 32'h0);
      checkOutput("t6_data0", wr_data[0], 32'hCAFEF00D);
      checkOutput("t6_addr1", wr_addr[1], 32'h4);
      checkOutput("t6_data1", wr_data[1], 32'h89ABCDEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
